// File: rtl/pipe_ctrl_pkg.sv
// Shared types and opcode constants for the LEGv8 hazard scheduler.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned INSTR_W = 32;

  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [7:0]  OP_CBNZ = 8'hB5;
  localparam logic [9:0]  OP_ADDI = 10'h244;
  localparam logic [9:0]  OP_SUBI = 10'h344;
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [5:0]  OP_B    = 6'h05;

  localparam logic [REG_W-1:0] XZR = 5'd31;

  // One in-flight destination tracked by the shadow pipe
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             ld;
  } shadow_entry_t;

  // Register usage of the instruction sitting in ID
  typedef struct packed {
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             use1;
    logic             use2;
    logic [REG_W-1:0] dst;
    logic             has_dst;
    logic             is_load;
  } dec_t;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2
  } hz_state_t;

  // XZR reads are constant zero, so they can never depend on an older write
  function automatic logic src_hit(input logic use_src, input logic [REG_W-1:0] src,
                                   input shadow_entry_t e);
    return use_src && (src != XZR) && e.v && (e.rd == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage request and pipeline-control response bundle.
//   master: pipeline side, drives id_valid/id_instr/br_taken_mem
//   slave : hazard scheduler, drives write enables, bubble, flushes, counters
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             id_valid;
  logic [31:0]      id_instr;
  logic             br_taken_mem;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             flush_ex_mem;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_valid, id_instr, br_taken_mem,
    input  pc_write, if_id_write, id_ex_bubble,
    input  flush_if_id, flush_id_ex, flush_ex_mem,
    input  stall_cycles, flush_events
  );

  modport slave (
    input  id_valid, id_instr, br_taken_mem,
    output pc_write, if_id_write, id_ex_bubble,
    output flush_if_id, flush_id_ex, flush_ex_mem,
    output stall_cycles, flush_events
  );
endinterface

// File: rtl/hz_decode.sv
// Combinational register-usage decode of the ID-stage instruction.
//   instr : instruction held in IF/ID
//   dec   : source/destination registers, use flags, load flag
module hz_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output dec_t               dec
);

  logic [10:0]      op11;
  logic [9:0]       op10;
  logic [7:0]       op8;
  logic [REG_W-1:0] rn;
  logic [REG_W-1:0] rm;
  logic [REG_W-1:0] rt;
  logic             unused_shamt;

  assign op11 = instr[31:21];
  assign op10 = instr[31:22];
  assign op8  = instr[31:24];
  assign rn   = instr[9:5];
  assign rm   = instr[20:16];
  assign rt   = instr[4:0];
  // shamt/imm bits carry no register information
  assign unused_shamt = ^instr[15:10];

  // Longest opcodes first; B and unknown encodings use no registers
  always_comb begin
    dec = '0;
    if (op11 == OP_ADD || op11 == OP_SUB || op11 == OP_AND || op11 == OP_ORR) begin
      dec.src1    = rn;
      dec.use1    = 1'b1;
      dec.src2    = rm;
      dec.use2    = 1'b1;
      dec.dst     = rt;
      dec.has_dst = 1'b1;
    end else if (op11 == OP_LDUR) begin
      dec.src1    = rn;
      dec.use1    = 1'b1;
      dec.dst     = rt;
      dec.has_dst = 1'b1;
      dec.is_load = 1'b1;
    end else if (op11 == OP_STUR) begin
      dec.src1 = rn;
      dec.use1 = 1'b1;
      dec.src2 = rt;
      dec.use2 = 1'b1;
    end else if (op10 == OP_ADDI || op10 == OP_SUBI) begin
      dec.src1    = rn;
      dec.use1    = 1'b1;
      dec.dst     = rt;
      dec.has_dst = 1'b1;
    end else if (op8 == OP_CBZ || op8 == OP_CBNZ) begin
      dec.src1 = rt;
      dec.use1 = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard scheduler for the 5-stage LEGv8 pipeline.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave): ID instruction + branch resolution in; PC/IF-ID enables,
//                ID/EX bubble, IF-ID/ID-EX/EX-MEM flushes and saturating
//                stall/flush counters out. Control outputs are combinational.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned CNT_W  = 32
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);

  dec_t             dec;
  shadow_entry_t    ex_q;
  shadow_entry_t    mem_q;
  shadow_entry_t    wb_q;
  hz_state_t        state_q;
  hz_state_t        state_d;
  logic             hit_ex_c;
  logic             hit_mem_c;
  logic             hazard_c;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic             unused_wb;

  hz_decode u_decode (
    .instr (bus.id_instr),
    .dec   (dec)
  );

  // WB writes before ID reads, so that entry is tracked but never compared
  assign unused_wb = ^wb_q;

  // RAW detection against in-flight destinations
  always_comb begin
    hit_ex_c  = src_hit(dec.use1, dec.src1, ex_q)  | src_hit(dec.use2, dec.src2, ex_q);
    hit_mem_c = src_hit(dec.use1, dec.src1, mem_q) | src_hit(dec.use2, dec.src2, mem_q);
    if (FWD_EN) begin
      hazard_c = hit_ex_c & ex_q.ld;
    end else begin
      hazard_c = hit_ex_c | hit_mem_c;
    end
  end

  // State register: class of the previous cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HZ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Cycle classification and control outputs; branch flush beats stall
  always_comb begin
    state_d          = HZ_RUN;
    bus.pc_write     = 1'b1;
    bus.if_id_write  = 1'b1;
    bus.id_ex_bubble = 1'b0;
    bus.flush_if_id  = 1'b0;
    bus.flush_id_ex  = 1'b0;
    bus.flush_ex_mem = 1'b0;
    if (reset) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.flush_if_id  = 1'b1;
      bus.flush_id_ex  = 1'b1;
      bus.flush_ex_mem = 1'b1;
    end else if (bus.br_taken_mem) begin
      state_d          = HZ_FLUSH;
      bus.flush_if_id  = 1'b1;
      bus.flush_id_ex  = 1'b1;
      bus.flush_ex_mem = 1'b1;
    end else if (bus.id_valid && hazard_c) begin
      state_d          = HZ_STALL;
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.id_ex_bubble = 1'b1;
    end
  end

  // Shadow pipe advance mirrors what the real pipeline registers do
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q <= mem_q;
      unique case (state_d)
        HZ_FLUSH: begin
          ex_q  <= '0;
          mem_q <= '0;
        end
        HZ_STALL: begin
          ex_q  <= '0;
          mem_q <= ex_q;
        end
        default: begin
          ex_q  <= '{v: bus.id_valid & dec.has_dst, rd: dec.dst, ld: dec.is_load};
          mem_q <= ex_q;
        end
      endcase
    end
  end

  // Event counters driven from the registered class; hold at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (state_q == HZ_STALL && stall_q != '1) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (state_q == HZ_FLUSH && flush_q != '1) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_events = flush_q;

endmodule
